truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//  Sequential stimulus/capture stage wrapped around the 4-input SOP function block (fxyzw).
//  On start it walks x,y,z,w through all 16 input vectors 0000..1111 (x = MSB).
//  After a settle window it samples the function output s and builds a 16-bit captured truth table.
//  At the end it compares the table to an expected minterm mask and reports pass/fail.
//  It replaces hand-written vector lists in self-checking regressions.
// PARAMETERS
//  SETTLE    2         cycles the vector is held before s is sampled (1..15)
//  EXPECTED  16'h5516  golden table, bit i = s for vector i; default = minterms {1,2,4,8,10,12,14}
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   request a full scan; sampled only in IDLE
//  abort       in   1   cancel a scan in progress; return to IDLE, no done pulse
//  s           in   1   output of the function block under scan
//  x,y,z,w     out  1   drive bits to the function block; x = vec[3], w = vec[0]
//  busy        out  1   high from start acceptance until done
//  done        out  1   one-cycle pulse when the result is valid
//  pass        out  1   result == EXPECTED; held until next start
//  result      out  16  captured table; bit i = s sampled for vector i
//  mismatches  out  5   popcount(result ^ EXPECTED), 0..16
//  first_fail  out  4   lowest i with result[i] != EXPECTED[i]; 0 when pass
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State = IDLE; x,y,z,w = 0.
//   - busy, done, pass, result, mismatches, first_fail = 0.
//   - Settle counter = 0; vec = 0.
//  FSM states: IDLE -> RUN -> CHECK -> IDLE.
//   - IDLE: start=1 at edge T0 -> RUN; vec=0, busy=1, result cleared, pass=0.
//   - RUN, per vector:
//     - Vector v is driven from edge T0+v*(SETTLE+1) and held SETTLE+1 cycles.
//     - At edge T0+(v+1)*(SETTLE+1), s is written to result[v] and vec increments.
//   - After result[15] is written: vec wraps to 0, outputs return to 0000, state -> CHECK.
//   - CHECK (1 cycle): registers pass, mismatches, first_fail. On the next edge done=1 for one
//     cycle, busy=0, state -> IDLE.
//   - Latency: start edge T0 to done high = 16*(SETTLE+1)+1 edges (49 for SETTLE=2).
//  Boundary cases:
//   - start while busy: ignored.
//   - start in the same cycle done is high: accepted (IDLE is re-entered with done).
//   - abort has priority over a sample on the same edge:
//     - State -> IDLE, busy=0, outputs -> 0000.
//     - result keeps the partial bits; pass/mismatches/first_fail are unchanged from reset/cleared.
//     - No done pulse.
//   - abort in IDLE or CHECK: no effect.
//   - Reset mid-scan: immediate return to reset values, regardless of clock.
//   - Vector counter is 4-bit and the scan end is detected at vec==15 before wrap. No 17th sample.
//  Widths:
//   - mismatches uses a 5-bit popcount, so 16 fits.
//   - first_fail uses a priority encoder, LSB first.
// STRUCTURE
//  - Shared package/header: state encoding (IDLE=2'd0, RUN=2'd1, CHECK=2'd2), VEC_W=4, N_VEC=16.
//  - One sub-module, tt_compare:
//    - Purely combinational.
//    - Inputs result and EXPECTED; outputs match, popcount, first-fail index.
//    - Registered in CHECK by the parent.
//  - The top contains the FSM, settle counter, vector counter and capture register.
//  - fxyzw is instantiated only in the bench, never inside this block.
// TESTING
//  1. Golden scan, fxyzw attached, SETTLE=2:
//     start pulse -> done at +49 cycles, result=16'h5516, pass=1, mismatches=0, first_fail=0.
//  2. Stuck-at-0 model on s -> result=16'h0000, pass=0, mismatches=7, first_fail=1.
//  3. Inverted fxyzw -> result=16'hAAE9, mismatches=16, first_fail=0.
//  4. Vector order check: log {x,y,z,w} at every sample edge -> exactly 0..15, ascending.
//     busy high for 49 cycles, then outputs 0000.
//  5. abort asserted at cycle 20 ->
//     - busy=0 at next edge; no done pulse.
//     - result[5:0] holds captured bits; bits above 5 = 0.
//     - A new start yields a full golden pass.
//  6. rst_n low at cycle 30, released at 33:
//     - All outputs 0 asynchronously.
//     - start asserted while busy is ignored (a second start at cycle 10 of a scan adds no extra done).

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: state encoding and vector sizing.
package truth_table_scanner_pkg;
  localparam int VEC_W = 4;
  localparam int N_VEC = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;
endpackage

// File: rtl/truth_table_scanner_compare.sv
// Combinational comparison of a captured truth table against the golden table.
module tt_compare
  import truth_table_scanner_pkg::*;
(
  input  logic [N_VEC-1:0] result,
  input  logic [N_VEC-1:0] expected,
  output logic             match,
  output logic [4:0]       popcount,
  output logic [3:0]       first_fail
);
  logic [N_VEC-1:0] diff;

  assign diff  = result ^ expected;
  assign match = (diff == '0);

  always_comb begin
    popcount   = 5'd0;
    first_fail = 4'd0;
    for (int i = 0; i < N_VEC; i++) begin
      popcount = popcount + 5'(diff[i]);
    end
    // Walk downwards so the lowest differing index is the last one written.
    for (int i = N_VEC - 1; i >= 0; i--) begin
      if (diff[i]) first_fail = 4'(i);
    end
  end
endmodule

// File: rtl/truth_table_scanner.sv
// Walks x,y,z,w through all 16 vectors, captures s after a settle window and grades the table.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int               SETTLE   = 2,
  parameter logic [N_VEC-1:0] EXPECTED = 16'h5516
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             s,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_VEC-1:0] result,
  output logic [4:0]       mismatches,
  output logic [3:0]       first_fail
);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state, state_nx;
  logic [VEC_W-1:0] vec;
  logic [3:0]       cnt;
  logic             start_acc;
  logic             sample;
  logic             cmp_match;
  logic [4:0]       cmp_pop;
  logic [3:0]       cmp_ff;

  assign start_acc = (state == ST_IDLE) && start;
  assign sample    = (state == ST_RUN) && !abort && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN: begin
        if (abort)                                      state_nx = ST_IDLE;
        else if (cnt == 4'd0 && vec == 4'(N_VEC - 1))   state_nx = ST_CHECK;
      end
      ST_CHECK: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Settle counter reloads on every sample, so each vector is held SETTLE+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      result     <= '0;
      mismatches <= 5'd0;
      first_fail <= 4'd0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        vec        <= '0;
        cnt        <= SETTLE_C;
        busy       <= 1'b1;
        result     <= '0;
        pass       <= 1'b0;
        mismatches <= 5'd0;
        first_fail <= 4'd0;
      end else if (state == ST_RUN) begin
        if (abort) begin
          vec  <= '0;
          cnt  <= 4'd0;
          busy <= 1'b0;
        end else if (sample) begin
          result[vec] <= s;
          vec         <= vec + 4'd1;
          cnt         <= SETTLE_C;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end else if (state == ST_CHECK) begin
        pass       <= cmp_match;
        mismatches <= cmp_pop;
        first_fail <= cmp_ff;
        done       <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

  assign x = vec[3];
  assign y = vec[2];
  assign z = vec[1];
  assign w = vec[0];

  tt_compare u_compare (
    .result     (result),
    .expected   (EXPECTED),
    .match      (cmp_match),
    .popcount   (cmp_pop),
    .first_fail (cmp_ff)
  );
endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner driving a behavioural fxyzw in several fault modes.
module tb_truth_table_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s;
  logic        x, y, z, w, busy, done, pass;
  logic [15:0] result;
  logic [4:0]  mismatches;
  logic [3:0]  first_fail;

  int          mode = 0;
  logic [15:0] gold_tt = 16'h5516;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  typedef struct {
    logic [15:0] res;
    logic        pass;
    logic [4:0]  mism;
    logic [3:0]  ff;
    int          t0;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt++;

  // fxyzw: minterms {1,2,4,8,10,12,14}; mode 1 = stuck-at-0, mode 2 = inverted.
  assign s = (mode == 1) ? 1'b0 :
             (mode == 2) ? ~gold_tt[{x, y, z, w}] : gold_tt[{x, y, z, w}];

  truth_table_scanner #(.SETTLE(2), .EXPECTED(16'h5516)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s(s),
    .x(x), .y(y), .z(z), .w(w), .busy(busy), .done(done), .pass(pass),
    .result(result), .mismatches(mismatches), .first_fail(first_fail)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", 32'(cyc - e.t0), 32'd49);
        check("result", 32'(result), 32'(e.res));
        check("pass", 32'(pass), 32'(e.pass));
        check("mismatches", 32'(mismatches), 32'(e.mism));
        check("first_fail", 32'(first_fail), 32'(e.ff));
      end
    end
  end

  task automatic do_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 100) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic push(input logic [15:0] r, input logic p, input logic [4:0] m,
                      input logic [3:0] f, input int t0);
    exp_t e;
    e.res = r; e.pass = p; e.mism = m; e.ff = f; e.t0 = t0;
    q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_xyzw"}, 32'({x, y, z, w}), 32'd0);
  endtask

  initial begin
    int t0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_mism", 32'(mismatches), 32'd0);
    check("rst_ff", 32'(first_fail), 32'd0);
    check("rst_xyzw", 32'({x, y, z, w}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Golden, stuck-at-0, inverted
    mode = 0; do_start(t0); push(16'h5516, 1'b1, 5'd0, 4'd0, t0); wait_done();
    @(negedge clk); check_idle_outputs("golden_after");
    mode = 1; do_start(t0); push(16'h0000, 1'b0, 5'd7, 4'd1, t0); wait_done();
    mode = 2; do_start(t0); push(16'hAAE9, 1'b0, 5'd16, 4'd0, t0); wait_done();

    // Vector order and busy width
    mode = 0; busy_cnt = 0;
    do_start(t0); push(16'h5516, 1'b1, 5'd0, 4'd0, t0);
    for (int v = 0; v < 16; v++) begin
      wait_cyc(t0 + 3 * v + 2);
      check($sformatf("vec_%0d", v), 32'({x, y, z, w}), 32'(v));
    end
    wait_done();
    @(negedge clk);
    check("busy_cycles", 32'(busy_cnt), 32'd49);
    check_idle_outputs("order_after");

    // Abort at cycle 20: six vectors captured, no done
    do_start(t0);
    wait_cyc(t0 + 19);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort_result", 32'(result), 32'h0016);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_mism", 32'(mismatches), 32'd0);
    check("abort_ff", 32'(first_fail), 32'd0);
    repeat (60) @(negedge clk);
    do_start(t0); push(16'h5516, 1'b1, 5'd0, 4'd0, t0); wait_done();

    // Start while busy is ignored
    do_start(t0); push(16'h5516, 1'b1, 5'd0, 4'd0, t0);
    wait_cyc(t0 + 9);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done();
    repeat (60) @(negedge clk);
    check("busy_start_no_extra", 32'(q.size()), 32'd0);

    // Asynchronous reset mid-scan
    do_start(t0);
    wait_cyc(t0 + 29);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    check("arst_result", 32'(result), 32'd0);
    check("arst_pass", 32'(pass), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    wait_cyc(t0 + 32);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("arst_stays_idle", 32'(busy), 32'd0);
    do_start(t0); push(16'h5516, 1'b1, 5'd0, 4'd0, t0); wait_done();
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
